// File: rtl/stream_pkg.sv
// Shared types and defaults for the stream sink blocks.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PROC = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_PROC_CYCLES = 4;
  localparam int DEF_LEN_W       = 8;
  localparam int PKT_CNT_W       = 16;

  // Counter width that stays at least one bit wide for a modulus of 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on rdata.
module stream_sync_fifo
  import stream_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_packet_sink.sv
// Stream sink: buffers beats in a FIFO and drains one beat every PROC_CYCLES,
// reporting per-packet beat count and a running packet total.
//
// state | meaning
// IDLE  | FIFO was empty last cycle; waiting for a buffered beat
// PROC  | processing the head beat; pops it when cnt reaches PROC_CYCLES-1
module stream_packet_sink
  import stream_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PROC_CYCLES = DEF_PROC_CYCLES,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        tdata,
  input  logic                     tvalid,
  input  logic                     tlast,
  output logic                     tready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     done,
  output logic [LEN_W-1:0]         pkt_len,
  output logic [PKT_CNT_W-1:0]     pkt_count,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = clog2_min1(PROC_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              push;
  logic              pop_fire;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   head;
  logic [FW-1:0]     fill_q;
  logic              stay_busy;

  assign tready    = !fifo_full;
  assign push      = tvalid && tready;
  assign pop_fire  = (state == PROC) && (cnt == CW'(PROC_CYCLES - 1));
  // Remaining occupancy after this pop, counting a beat written on the same edge.
  assign stay_busy = (fill_q > FW'(1)) || push;
  assign fill      = fill_q;

  stream_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({tdata, tlast}),
    .pop   (pop_fire),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_q)
  );

  // Sequencer, processing timer, packet counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      beat_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      pkt_len    <= '0;
      pkt_count  <= '0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!fifo_empty) state <= PROC;
        end
        PROC: begin
          if (pop_fire) begin
            data_out   <= head[DATA_W:1];
            data_valid <= 1'b1;
            if (head[0]) begin
              done      <= 1'b1;
              pkt_len   <= (beat_cnt == LEN_MAX) ? LEN_MAX : beat_cnt + 1'b1;
              beat_cnt  <= '0;
              pkt_count <= pkt_count + 1'b1;
            end else if (beat_cnt != LEN_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            cnt <= '0;
            if (!stay_busy) state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
